// File: rtl/sw_frame_unit.sv
// sw_frame_unit
//
// Per-switch consumer of the shared frame bus. Frames pushed with fifo_wr_en are
// buffered in a small FIFO, popped in order by a three-state FSM, and applied to
// a local register bank as a write or a read. Every completed frame produces one
// response on a valid/ready handshake.
//
// Frame layout: {unused[31:22], addr[21:17], wr_rd[16], wr_data[15:8], op_id[7:0]}
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   fifo_wr_en   push strobe for frame_in
//   frame_in     incoming frame
//   fifo_full    FIFO holds FIFO_DEPTH frames (registered)
//   fifo_empty   FIFO holds no frames (registered)
//   drop_cnt     frames dropped because the FIFO was full, saturating at 255
//   resp_valid   response available
//   resp_ready   consumer accepts the response
//   resp_op_id   op_id of the completed frame
//   resp_wr      1 = write completed, 0 = read completed
//   resp_data    write: data written; read: register content
module sw_frame_unit #(
    parameter int unsigned FRAME_WIDTH = 32,
    parameter int unsigned W_WIDTH     = 8,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned NUM_REGS    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   fifo_wr_en,
    input  logic [FRAME_WIDTH-1:0] frame_in,
    output logic                   fifo_full,
    output logic                   fifo_empty,
    output logic [7:0]             drop_cnt,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [7:0]             resp_op_id,
    output logic                   resp_wr,
    output logic [W_WIDTH-1:0]     resp_data
);

    // Frame field positions
    localparam int unsigned ID_LSB   = 0;
    localparam int unsigned DATA_LSB = 8;
    localparam int unsigned WR_BIT   = 16;
    localparam int unsigned ADDR_LSB = 17;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned USED_W   = ADDR_LSB + ADDR_W;

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

    // ------------------------------------------------------------------
    // Frame FIFO
    // ------------------------------------------------------------------
    logic [USED_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              push;
    logic              drop;
    logic              pop;
    logic [USED_W-1:0] head;

    // Bits above the address field carry nothing for this unit.
    logic unused_frame_bits;
    assign unused_frame_bits = ^frame_in[FRAME_WIDTH-1:USED_W];

    // Acceptance is decided by the registered full flag, so a push while full
    // is dropped even when a pop happens on the same edge.
    assign push = fifo_wr_en && !fifo_full;
    assign drop = fifo_wr_en && fifo_full;
    assign head = fifo_mem[rd_ptr_q];

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= frame_in[USED_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            fifo_full  <= 1'b0;
            fifo_empty <= 1'b1;
            drop_cnt   <= '0;
        end else begin
            // Pointers wrap naturally because FIFO_DEPTH is a power of two.
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            cnt_q      <= cnt_d;
            fifo_full  <= (cnt_d == CNT_W'(FIFO_DEPTH));
            fifo_empty <= (cnt_d == '0);
            if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and response registers
    // ------------------------------------------------------------------
    state_e            state_q;
    logic [USED_W-1:0] hold_q;
    logic [ADDR_W-1:0] hold_addr;
    logic              hold_wr;
    logic [W_WIDTH-1:0] hold_data;
    logic [7:0]        hold_id;
    logic [W_WIDTH-1:0] regs [NUM_REGS];

    assign hold_addr = hold_q[ADDR_LSB +: ADDR_W];
    assign hold_wr   = hold_q[WR_BIT];
    assign hold_data = hold_q[DATA_LSB +: W_WIDTH];
    assign hold_id   = hold_q[ID_LSB +: 8];

    // The FSM takes the head frame when idle, or directly at the response
    // handshake so back-to-back frames complete every two cycles.
    always_comb begin
        pop = 1'b0;
        if (!fifo_empty) begin
            if (state_q == StIdle) begin
                pop = 1'b1;
            end else if ((state_q == StResp) && resp_ready) begin
                pop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            hold_q     <= '0;
            resp_valid <= 1'b0;
            resp_op_id <= '0;
            resp_wr    <= 1'b0;
            resp_data  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        hold_q  <= head;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    // A read returns the bank content from before this edge.
                    resp_data  <= hold_wr ? hold_data : regs[hold_addr];
                    resp_op_id <= hold_id;
                    resp_wr    <= hold_wr;
                    resp_valid <= 1'b1;
                    state_q    <= StResp;
                end
                StResp: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        if (pop) begin
                            hold_q  <= head;
                            state_q <= StExec;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: begin
                    state_q    <= StIdle;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register bank: the only write path is a write frame in EXEC.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if ((state_q == StExec) && hold_wr) begin
            regs[hold_addr] <= hold_data;
        end
    end

endmodule

// File: tb/tb_sw_frame_unit.sv
// Self-checking bench for sw_frame_unit: directed steps from reset through
// backpressure, overflow and mid-operation reset, then a randomized phase
// checked against a transaction-level model (ordered queue plus register array).
module tb_sw_frame_unit;

    localparam int unsigned FW = 32;
    localparam int unsigned WW = 8;
    localparam int unsigned FD = 4;
    localparam int unsigned NR = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_wr_en = 1'b0;
    logic [FW-1:0] frame_in = '0;
    logic          resp_ready = 1'b0;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    drop_cnt;
    logic          resp_valid;
    logic [7:0]    resp_op_id;
    logic          resp_wr;
    logic [WW-1:0] resp_data;

    sw_frame_unit #(
        .FRAME_WIDTH(FW),
        .W_WIDTH    (WW),
        .FIFO_DEPTH (FD),
        .NUM_REGS   (NR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fifo_wr_en(fifo_wr_en),
        .frame_in  (frame_in),
        .fifo_full (fifo_full),
        .fifo_empty(fifo_empty),
        .drop_cnt  (drop_cnt),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_op_id(resp_op_id),
        .resp_wr   (resp_wr),
        .resp_data (resp_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0]    id;
        logic          wr;
        logic [WW-1:0] data;
    } resp_t;

    resp_t         expq[$];
    logic [WW-1:0] mregs[NR];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Unused upper bits are filled with noise; the unit must ignore them.
    function automatic logic [FW-1:0] mk(input logic [4:0] a, input logic w,
                                         input logic [7:0] d, input logic [7:0] id);
        logic [9:0] junk;
        junk = 10'($urandom);
        return {junk, a, w, d, id};
    endfunction

    // Drive one push; returns at the negedge after the push edge.
    task automatic push_f(input logic [4:0] a, input logic w, input logic [7:0] d,
                          input logic [7:0] id);
        fifo_wr_en = 1'b1;
        frame_in   = mk(a, w, d, id);
        @(negedge clk);
        fifo_wr_en = 1'b0;
    endtask

    // Wait (bounded) for resp_valid, compare, then step past the handshake edge.
    task automatic wait_resp(input string tag, input logic [7:0] id, input logic wr,
                             input logic [7:0] data, output int waited);
        waited = 0;
        while (resp_valid !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, "_valid"}, resp_valid, 1);
        if (resp_valid === 1'b1) begin
            chk({tag, "_id"}, resp_op_id, id);
            chk({tag, "_wr"}, resp_wr, wr);
            chk({tag, "_data"}, resp_data, data);
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end expected finish");
        $fatal(1);
    end

    initial begin
        int            g;
        int            outstanding;
        resp_t         e;
        logic [4:0]    a;
        logic          w;
        logic [7:0]    d;

        // ---------------- reset then idle ----------------
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_empty", fifo_empty, 1);
        chk("rst_full", fifo_full, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_valid", resp_valid, 0);
        chk("rst_id", resp_op_id, 0);
        chk("rst_wr", resp_wr, 0);
        chk("rst_data", resp_data, 0);
        rst_n      = 1'b1;
        resp_ready = 1'b1;
        @(negedge clk);

        // ---------------- single write, latency ----------------
        push_f(5'd5, 1'b1, 8'hA5, 8'h11);
        chk("lat_e0_valid", resp_valid, 0);
        chk("lat_e0_empty", fifo_empty, 0);
        @(negedge clk);
        chk("lat_e1_valid", resp_valid, 0);
        chk("lat_e1_empty", fifo_empty, 1);
        @(negedge clk);
        chk("lat_e2_valid", resp_valid, 1);
        chk("lat_e2_id", resp_op_id, 8'h11);
        chk("lat_e2_wr", resp_wr, 1);
        chk("lat_e2_data", resp_data, 8'hA5);
        @(negedge clk);
        chk("lat_e3_valid", resp_valid, 0);
        repeat (2) @(negedge clk);

        // ---------------- read after write ----------------
        push_f(5'd5, 1'b1, 8'hA5, 8'h10);
        push_f(5'd5, 1'b0, 8'h00, 8'h12);
        push_f(5'd6, 1'b0, 8'h00, 8'h13);
        wait_resp("raw_w5", 8'h10, 1'b1, 8'hA5, g);
        wait_resp("raw_r5", 8'h12, 1'b0, 8'hA5, g);
        wait_resp("raw_r6", 8'h13, 1'b0, 8'h00, g);
        repeat (2) @(negedge clk);

        // ---------------- backpressure and overflow ----------------
        resp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push_f(5'(8 + i), 1'b1, 8'(8'h30 + i), 8'(8'h20 + i));
        end
        chk("ovf_full", fifo_full, 1);
        chk("ovf_drop", drop_cnt, 1);
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", resp_valid, 1);
            chk("stall_id", resp_op_id, 8'h20);
            chk("stall_wr", resp_wr, 1);
            chk("stall_data", resp_data, 8'h30);
            @(negedge clk);
        end
        chk("stall_full", fifo_full, 1);
        resp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_resp("drain", 8'(8'h20 + i), 1'b1, 8'(8'h30 + i), g);
            if (i > 0) chk("drain_gap", g, 1);
        end
        chk("drain_empty", fifo_empty, 1);
        chk("drain_valid", resp_valid, 0);
        chk("drain_drop", drop_cnt, 1);
        repeat (2) @(negedge clk);

        // ---------------- simultaneous push and pop ----------------
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_f(5'(8 + i), 1'b0, 8'h00, 8'(8'h40 + i));
        end
        chk("sim_pre_valid", resp_valid, 1);
        chk("sim_pre_id", resp_op_id, 8'h40);
        chk("sim_pre_data", resp_data, 8'h30);
        chk("sim_pre_wr", resp_wr, 0);
        resp_ready = 1'b1;
        push_f(5'd11, 1'b0, 8'h00, 8'h43);  // handshake and push on one edge
        resp_ready = 1'b0;
        chk("sim_full0", fifo_full, 0);
        chk("sim_drop0", drop_cnt, 1);
        push_f(5'd12, 1'b0, 8'h00, 8'h44);
        chk("sim_full1", fifo_full, 0);
        push_f(5'd13, 1'b0, 8'h00, 8'h45);
        chk("sim_full2", fifo_full, 1);
        chk("sim_drop2", drop_cnt, 1);
        resp_ready = 1'b1;
        wait_resp("sim_r1", 8'h41, 1'b0, 8'h31, g);
        wait_resp("sim_r2", 8'h42, 1'b0, 8'h32, g);
        wait_resp("sim_r3", 8'h43, 1'b0, 8'h33, g);
        wait_resp("sim_r4", 8'h44, 1'b0, 8'h34, g);
        wait_resp("sim_r5", 8'h45, 1'b0, 8'h00, g);  // addr 13 write was dropped
        repeat (2) @(negedge clk);

        // ---------------- reset mid-operation ----------------
        resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_f(5'd5, 1'b0, 8'h00, 8'(8'h60 + i));
        end
        chk("mid_pre_valid", resp_valid, 1);
        chk("mid_pre_empty", fifo_empty, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", resp_valid, 0);
        chk("mid_rst_empty", fifo_empty, 1);
        chk("mid_rst_full", fifo_full, 0);
        chk("mid_rst_drop", drop_cnt, 0);
        chk("mid_rst_id", resp_op_id, 0);
        chk("mid_rst_wr", resp_wr, 0);
        chk("mid_rst_data", resp_data, 0);
        repeat (2) @(negedge clk);
        rst_n      = 1'b1;
        resp_ready = 1'b1;
        @(negedge clk);
        push_f(5'd5, 1'b0, 8'h00, 8'h50);
        push_f(5'd8, 1'b0, 8'h00, 8'h51);
        wait_resp("post_r5", 8'h50, 1'b0, 8'h00, g);
        wait_resp("post_r8", 8'h51, 1'b0, 8'h00, g);
        repeat (2) @(negedge clk);

        // ---------------- randomized phase ----------------
        for (int i = 0; i < NR; i++) mregs[i] = '0;
        expq.delete();
        outstanding = 0;
        for (int c = 0; c < 600; c++) begin
            resp_ready = ($urandom_range(0, 3) != 0);
            if (resp_valid === 1'b1 && resp_ready) begin
                if (expq.size() == 0) begin
                    chk("rnd_spurious", resp_valid, 0);
                end else begin
                    e = expq.pop_front();
                    chk("rnd_id", resp_op_id, e.id);
                    chk("rnd_wr", resp_wr, e.wr);
                    chk("rnd_data", resp_data, e.data);
                    outstanding--;
                end
            end
            // Never more than FIFO_DEPTH frames in flight, so nothing may drop.
            if (outstanding < FD && $urandom_range(0, 1) == 1) begin
                a = 5'($urandom_range(0, 7));
                w = 1'($urandom_range(0, 1));
                d = 8'($urandom);
                e.id = 8'(c);
                e.wr = w;
                if (w) begin
                    mregs[a] = d;
                    e.data   = d;
                end else begin
                    e.data = mregs[a];
                end
                expq.push_back(e);
                frame_in   = mk(a, w, d, e.id);
                fifo_wr_en = 1'b1;
                outstanding++;
            end else begin
                fifo_wr_en = 1'b0;
            end
            @(negedge clk);
        end
        fifo_wr_en = 1'b0;
        resp_ready = 1'b1;
        g = 0;
        while (expq.size() > 0 && g < 100) begin
            if (resp_valid === 1'b1) begin
                e = expq.pop_front();
                chk("rnd_id", resp_op_id, e.id);
                chk("rnd_wr", resp_wr, e.wr);
                chk("rnd_data", resp_data, e.data);
            end
            @(negedge clk);
            g++;
        end
        chk("rnd_drained", expq.size(), 0);
        chk("rnd_drop", drop_cnt, 0);
        chk("rnd_empty", fifo_empty, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
